// File: rtl/decode_ctrl_stage_if.sv
// rtl/decode_ctrl_stage_if.sv - handshake and control-bundle bus for the decode/control stage
//
// Purpose: groups the IF/ID-side input handshake and the EX-side output bundle
//          of decode_ctrl_stage into one bundle.
// Signals:
//   in_valid/in_ready/in_instr/in_pc   instruction from the IF/ID register
//   out_valid/out_ready                control bundle handshake towards EX
//   out_pc, rs1, rs2, rd, funct3       registered instruction fields
//   alu_op, imm_type, mem_size         registered decode results
//   branch .. mem_unsigned, illegal    registered control flags
// Modports:
//   master  pipeline side (drives instructions, accepts bundles)
//   slave   the decode/control stage itself
interface decode_ctrl_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  alu_op;
  logic        branch;
  logic        mem_read;
  logic        mem_to_reg;
  logic        mem_write;
  logic        alu_src;
  logic        reg_write;
  logic        jump;
  logic        jalr;
  logic        mem_unsigned;
  logic [2:0]  imm_type;
  logic [1:0]  mem_size;
  logic        illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, rs1, rs2, rd, funct3, alu_op,
           branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write,
           jump, jalr, mem_unsigned, imm_type, mem_size, illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, rs1, rs2, rd, funct3, alu_op,
           branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write,
           jump, jalr, mem_unsigned, imm_type, mem_size, illegal
  );
endinterface

// File: rtl/decode_ctrl_stage.sv
// rtl/decode_ctrl_stage.sv - registered RV32I(M) decode/control stage with load-use bubble
//
// Purpose: decodes the instruction offered by IF/ID into the control bundle and
//          holds it in one output register with valid/ready flow control.
//          Stalls one cycle on a load-use hazard against the held bundle,
//          honours flushes, flags illegal encodings and counts issues/bubbles.
// Ports:
//   clk         core clock
//   rst         synchronous active-high reset
//   bus         decode_ctrl_stage_if.slave (input handshake + output bundle)
//   flush       kill held and incoming instruction
//   issue_cnt   bundles accepted by EX (wraps)
//   bubble_cnt  cycles a load-use bubble was inserted (wraps)
module decode_ctrl_stage #(
  parameter bit ENABLE_M = 1'b1,
  parameter int CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  decode_ctrl_stage_if.slave   bus,
  input  logic                 flush,
  output logic [CNT_W-1:0]     issue_cnt,
  output logic [CNT_W-1:0]     bubble_cnt
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_AND  = 5'b00010;
  localparam logic [4:0] ALU_OR   = 5'b00011;
  localparam logic [4:0] ALU_XOR  = 5'b00100;
  localparam logic [4:0] ALU_SLL  = 5'b00101;
  localparam logic [4:0] ALU_SRL  = 5'b00110;
  localparam logic [4:0] ALU_SRA  = 5'b00111;
  localparam logic [4:0] ALU_SLT  = 5'b01000;
  localparam logic [4:0] ALU_SLTU = 5'b01001;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  alu_op;
    logic        branch;
    logic        mem_read;
    logic        mem_to_reg;
    logic        mem_write;
    logic        alu_src;
    logic        reg_write;
    logic        jump;
    logic        jalr;
    logic        mem_unsigned;
    logic [2:0]  imm_type;
    logic [1:0]  mem_size;
    logic        illegal;
  } ctrl_t;

  ctrl_t            ctrl_d, ctrl_q;
  logic             out_valid_q;
  logic [CNT_W-1:0] issue_cnt_q, bubble_cnt_q;
  logic             uses_rs1, uses_rs2, haz, in_ready;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  assign opcode = bus.in_instr[6:0];
  assign f3     = bus.in_instr[14:12];
  assign f7     = bus.in_instr[31:25];

  // Shared ALU map for register and immediate arithmetic; alt selects SUB/SRA.
  function automatic logic [4:0] alu_base(input logic [2:0] fn, input logic alt);
    case (fn)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin
    logic ill;
    ill             = 1'b0;
    ctrl_d          = '0;
    ctrl_d.mem_size = 2'b10;
    ctrl_d.pc       = bus.in_pc;
    ctrl_d.rs1      = bus.in_instr[19:15];
    ctrl_d.rs2      = bus.in_instr[24:20];
    ctrl_d.rd       = bus.in_instr[11:7];
    ctrl_d.funct3   = f3;
    uses_rs1        = 1'b1;
    uses_rs2        = 1'b0;

    case (opcode)
      OP_REG: begin
        uses_rs2         = 1'b1;
        ctrl_d.reg_write = 1'b1;
        case (f7)
          7'b0000000: ctrl_d.alu_op = alu_base(f3, 1'b0);
          7'b0100000: begin
            if (f3 == 3'b000 || f3 == 3'b101) ctrl_d.alu_op = alu_base(f3, 1'b1);
            else                               ill = 1'b1;
          end
          7'b0000001: begin
            if (ENABLE_M) ctrl_d.alu_op = {2'b10, f3};
            else          ill = 1'b1;
          end
          default: ill = 1'b1;
        endcase
      end
      OP_IMM: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.imm_type  = 3'b001;
        // Only the right-shift immediate uses instr[30] as the arithmetic select.
        ctrl_d.alu_op    = alu_base(f3, (f3 == 3'b101) && bus.in_instr[30]);
      end
      OP_LOAD: begin
        ctrl_d.mem_read     = 1'b1;
        ctrl_d.mem_to_reg   = 1'b1;
        ctrl_d.reg_write    = 1'b1;
        ctrl_d.alu_src      = 1'b1;
        ctrl_d.imm_type     = 3'b001;
        ctrl_d.mem_size     = f3[1:0];
        ctrl_d.mem_unsigned = f3[2];
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) ill = 1'b1;
      end
      OP_STORE: begin
        uses_rs2         = 1'b1;
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.imm_type  = 3'b010;
        ctrl_d.mem_size  = f3[1:0];
        if (f3 > 3'b010) ill = 1'b1;
      end
      OP_BRANCH: begin
        uses_rs2        = 1'b1;
        ctrl_d.branch   = 1'b1;
        ctrl_d.imm_type = 3'b011;
        // BEQ/BNE map to 101x, the four ordered compares to 11xx.
        ctrl_d.alu_op   = f3[2] ? {3'b011, f3[1:0]} : {4'b0101, f3[0]};
        if (f3 == 3'b010 || f3 == 3'b011) ill = 1'b1;
      end
      OP_JAL: begin
        uses_rs1         = 1'b0;
        ctrl_d.jump      = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.imm_type  = 3'b101;
      end
      OP_JALR: begin
        ctrl_d.jalr      = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.imm_type  = 3'b001;
      end
      OP_LUI, OP_AUIPC: begin
        uses_rs1         = 1'b0;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.imm_type  = 3'b100;
      end
      OP_FENCE: ;
      default: ill = 1'b1;
    endcase

    // Illegal bundles still flow to EX but must not change architectural state.
    if (ill) begin
      ctrl_d.branch    = 1'b0;
      ctrl_d.mem_read  = 1'b0;
      ctrl_d.mem_write = 1'b0;
      ctrl_d.reg_write = 1'b0;
      ctrl_d.jump      = 1'b0;
      ctrl_d.jalr      = 1'b0;
    end
    ctrl_d.illegal = ill;
  end

  // Load-use check against the held bundle, using the incoming register fields.
  assign haz = out_valid_q && ctrl_q.mem_read && (ctrl_q.rd != 5'd0) &&
               ((uses_rs1 && ctrl_q.rd == bus.in_instr[19:15]) ||
                (uses_rs2 && ctrl_q.rd == bus.in_instr[24:20]));

  assign in_ready = (!out_valid_q || bus.out_ready) && !haz && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q     <= 1'b0;
      ctrl_q          <= '0;
      ctrl_q.mem_size <= 2'b10;
      issue_cnt_q     <= '0;
      bubble_cnt_q    <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready) issue_cnt_q <= issue_cnt_q + CNT_W'(1);
      if (bus.in_valid && in_ready) begin
        ctrl_q      <= ctrl_d;
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
        if (haz) bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_pc       = ctrl_q.pc;
  assign bus.rs1          = ctrl_q.rs1;
  assign bus.rs2          = ctrl_q.rs2;
  assign bus.rd           = ctrl_q.rd;
  assign bus.funct3       = ctrl_q.funct3;
  assign bus.alu_op       = ctrl_q.alu_op;
  assign bus.branch       = ctrl_q.branch;
  assign bus.mem_read     = ctrl_q.mem_read;
  assign bus.mem_to_reg   = ctrl_q.mem_to_reg;
  assign bus.mem_write    = ctrl_q.mem_write;
  assign bus.alu_src      = ctrl_q.alu_src;
  assign bus.reg_write    = ctrl_q.reg_write;
  assign bus.jump         = ctrl_q.jump;
  assign bus.jalr         = ctrl_q.jalr;
  assign bus.mem_unsigned = ctrl_q.mem_unsigned;
  assign bus.imm_type     = ctrl_q.imm_type;
  assign bus.mem_size     = ctrl_q.mem_size;
  assign bus.illegal      = ctrl_q.illegal;
  assign issue_cnt        = issue_cnt_q;
  assign bubble_cnt       = bubble_cnt_q;

endmodule

// File: doc/decode_ctrl_stage.md
Name: decode_ctrl_stage

Overview:
- Registered, handshaked decode/control stage for the pipelined RV32I core.
- Sits between the IF/ID register and EX. Decodes each instruction into the control bundle and holds it in a single output register with valid/ready flow control.
- Detects load-use hazards against the instruction it holds and inserts a one-cycle bubble.
- Honours branch/jump flushes, flags illegal encodings, optionally decodes RV32M, and keeps issue/bubble performance counters.

Parameters:
- ENABLE_M, 1, 1: decode RV32M ops (funct7=0000001 on opcode 0110011); 0: those encodings are illegal.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  IF/ID holds a valid instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_instr  in  32  instruction word
- in_pc  in  32  instruction PC
- flush  in  1  kill held and incoming instruction (branch mispredict/jump)
- out_valid  out  1  control bundle valid to EX
- out_ready  in  1  EX accepts the bundle
- out_pc  out  32  registered PC
- rs1, rs2, rd  out  5 each  register fields (instr[19:15], [24:20], [11:7])
- funct3  out  3  instr[14:12], registered
- alu_op  out  5  ALU operation code
- branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, jump, jalr, mem_unsigned  out  1 each  control flags
- imm_type  out  3  000 none/R, 001 I, 010 S, 011 B, 100 U, 101 J
- mem_size  out  2  00 byte, 01 half, 10 word
- illegal  out  1  instruction is an unsupported encoding
- issue_cnt  out  CNT_W  bundles accepted by EX
- bubble_cnt  out  CNT_W  cycles a load-use bubble was inserted

Behaviour:
- Reset:
  - out_valid=0; all control flags, alu_op, imm_type and illegal = 0.
  - mem_size=2'b10; out_pc, rs1, rs2, rd, funct3 = 0; both counters = 0.
- Decode (combinational, then registered on accept):
  - Base encodings use alu_op[4]=0 with codes ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001, BEQ 1010, BNE 1011, BLT 1100, BGE 1101, BLTU 1110, BGEU 1111.
  - SUB and SRA are selected by funct7=0100000. SRAI is selected by instr[30].
  - RV32M (ENABLE_M=1) uses alu_op 10000-10111, indexed by funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - Loads: mem_read=1, mem_to_reg=1.
    - LB: mem_size=00. LBU: mem_size=00, mem_unsigned=1.
    - LH: mem_size=01. LHU: mem_size=01, mem_unsigned=1.
    - LW: mem_size=10.
  - Stores: mem_write=1, imm_type=010; mem_size from funct3 (SB 00, SH 01, SW 10).
  - JAL: jump=1, imm_type=101. JALR: jalr=1, imm_type=001. LUI/AUIPC: imm_type=100. FENCE: no-op, legal.
- Illegal:
  - Conditions: unknown opcode; load funct3 011/110/111; store funct3 >010; branch funct3 010/011; M encoding with ENABLE_M=0; R-type funct7 other than 0000000, 0100000 (SUB/SRA only), or 0000001 (when M enabled).
  - Response: illegal=1 and branch, mem_read, mem_write, reg_write, jump, jalr = 0. The bundle still flows downstream.
- Hazard:
  - haz = out_valid & mem_read & (rd!=0) & ((uses_rs1 & rd==in rs1) | (uses_rs2 & rd==in rs2)).
  - uses_rs1 is false for LUI, AUIPC, JAL. uses_rs2 is true only for R-type, stores, branches.
- Handshake:
  - in_ready = (!out_valid | out_ready) & !haz & !flush.
  - Load into the output register when in_valid & in_ready.
  - On out_ready & haz: out_valid<=0 (bubble), bubble_cnt++. The instruction is accepted the following cycle; single-cycle bubble.
  - Without new accept and with out_ready: out_valid<=0.
  - out_ready=0 holds all outputs stable.
- Flush:
  - Priority is below rst, above everything else. Sets out_valid<=0 and accepts no input that cycle.
  - A simultaneous out_ready does not count an issue.
- Counters:
  - issue_cnt++ when out_valid & out_ready & !flush. bubble_cnt++ as above.
  - Both wrap modulo 2^CNT_W.
- Latency: one cycle from accept to out_valid. Full throughput (1/cycle) when no hazard and out_ready=1.

Test Plan:
- Reset, then stream ADD x3,x1,x2 (0x002081B3) with out_ready=1 -> next cycle: out_valid=1, alu_op=00000, reg_write=1, rd=3, illegal=0, mem_size=10; issue_cnt=1 after the EX accept.
- LW x5,0(x1) (0x0000A283) then ADD x6,x5,x2 (0x00228333) back-to-back:
  - in_ready=0 for exactly one cycle; out_valid=0 for one cycle after the LW issues; bubble_cnt=1.
  - The ADD then issues with rs1=5.
- MUL x3,x1,x2 (0x022081B3) -> ENABLE_M=1: alu_op=10000, illegal=0. ENABLE_M=0: illegal=1, reg_write=0.
- out_ready held 0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0, issue_cnt unchanged. Release -> both instructions issue in order.
- flush asserted while out_valid=1 and in_valid=1 -> next cycle out_valid=0, the input is not consumed, issue_cnt unchanged.
- Opcode 0x7F (word 0x0000007F) -> illegal=1, all write/branch flags 0. rst asserted mid-stream -> every output at its reset value on the next edge.
